// File: rtl/keccak_pkg.sv
// keccak_pkg
//   Shared types for the keccak byte packer: the word record that travels
//   through the packer FIFO, the packer FSM state encoding and the number of
//   bytes per keccak input word.
//   No ports (package).
package keccak_pkg;

  localparam int WORD_BYTES = 4;

  // One keccak input word plus the final-word markers that accompany it.
  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [1:0]  bn;
  } kpack_word_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PAD   = 2'd1,
    DRAIN = 2'd2
  } kpack_state_t;

endpackage

// File: rtl/kpack_word_fifo.sv
// kpack_word_fifo
//   Small word FIFO between the byte packer and the keccak core. Storage is
//   registered; the head entry is presented combinationally (fall-through),
//   so a word written at one edge is visible right after that edge.
//   The head drives all zeros while the FIFO is empty.
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset, empties the FIFO
//   push       in   write push_word (ignored while full)
//   push_word  in   word record to write
//   pop        in   drop the head entry (ignored while empty)
//   head       out  current head entry, zero when empty
//   full       out  DEPTH entries held
//   empty      out  no entries held
module kpack_word_fifo
  import keccak_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  kpack_word_t push_word,
  input  logic        pop,
  output kpack_word_t head,
  output logic        full,
  output logic        empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  kpack_word_t     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage, pointers and occupancy. DEPTH is a power of two, so the
  // pointers wrap naturally; a simultaneous push and pop leaves the count
  // unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keccak_byte_packer.sv
// keccak_byte_packer
//   Upstream feeder for the keccak core. Packs a valid/ready byte stream
//   big-endian into 32-bit words (first byte in [31:24]) and presents them to
//   keccak through a small FIFO. A partial final word carries byte_num 1..3;
//   a message whose length is a multiple of 4 is followed by an all-zero word
//   with byte_num 0 and is_last 1.
//   Optional feature macro: KPACK_MSG_LEN_EN adds the msg_len output.
// Ports
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-high reset
//   s_data        in   message byte
//   s_valid       in   s_data valid
//   s_last        in   s_data is the final byte of the message
//   s_ready       out  byte accepted when s_valid & s_ready
//   k_in          out  word to keccak.in (zero when nothing queued)
//   k_in_ready    out  word available for keccak
//   k_is_last     out  word is the final word of the message
//   k_byte_num    out  valid bytes in the final word (0..3)
//   k_buffer_full in   keccak cannot take a word this cycle
//   msg_done      out  pulse in the cycle the final word is consumed
//   msg_len       out  (KPACK_MSG_LEN_EN only) accepted bytes of the message
module keccak_byte_packer
  import keccak_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [31:0] k_in,
  output logic        k_in_ready,
  output logic        k_is_last,
  output logic [1:0]  k_byte_num,
  input  logic        k_buffer_full,
  output logic        msg_done
`ifdef KPACK_MSG_LEN_EN
  , output logic [31:0] msg_len
`endif
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  kpack_state_t state;
  logic [31:0]  acc;
  logic [1:0]   byte_cnt;
  logic [31:0]  merged;
  logic         accept;
  logic         push;
  kpack_word_t  push_word;
  logic         pop;
  kpack_word_t  head;
  logic         fifo_full;
  logic         fifo_empty;

  // Bytes are only taken while filling and while there is FIFO room; reset
  // is included so s_ready is held low for the whole reset interval.
  assign s_ready = (state == FILL) && !fifo_full && !reset;
  assign accept  = s_valid && s_ready;

  // Current byte dropped into its big-endian lane on top of the bytes
  // already collected; lanes not yet written stay zero.
  assign merged = acc | ({s_data, 24'h0} >> {byte_cnt, 3'b000});

  // Decide what, if anything, enters the FIFO this cycle: a full word, a
  // partial final word, or the zero padding word after a 4-byte-aligned end.
  always_comb begin
    push      = 1'b0;
    push_word = '0;
    case (state)
      FILL: begin
        if (accept) begin
          if (byte_cnt == LAST_IDX) begin
            push      = 1'b1;
            push_word = '{data: merged, last: 1'b0, bn: 2'd0};
          end else if (s_last) begin
            push      = 1'b1;
            push_word = '{data: merged, last: 1'b1, bn: byte_cnt + 2'd1};
          end
        end
      end
      PAD: begin
        if (!fifo_full) begin
          push      = 1'b1;
          push_word = '{data: 32'h0, last: 1'b1, bn: 2'd0};
        end
      end
      default: begin
        push      = 1'b0;
        push_word = '0;
      end
    endcase
  end

  kpack_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign k_in_ready = !fifo_empty;
  assign pop        = k_in_ready && !k_buffer_full;
  assign k_in       = head.data;
  assign k_is_last  = head.last;
  assign k_byte_num = head.bn;
  assign msg_done   = pop && head.last;

  // Packer FSM with accumulator and byte counter. A final byte that
  // completes a word still needs the padding word, hence the PAD detour;
  // DRAIN holds off the next message until keccak has taken the final word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= FILL;
      acc      <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            if ((byte_cnt == LAST_IDX) || s_last) begin
              acc      <= '0;
              byte_cnt <= '0;
            end else begin
              acc      <= merged;
              byte_cnt <= byte_cnt + 2'd1;
            end
            if (s_last) begin
              state <= (byte_cnt == LAST_IDX) ? PAD : DRAIN;
            end
          end
        end
        PAD: begin
          if (!fifo_full) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (msg_done) begin
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef KPACK_MSG_LEN_EN
  logic in_msg;

  // Byte counter for the current message. The first byte of a message
  // restarts it at 1, so the final length stays visible from the end of the
  // message through msg_done until the next message begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_len <= '0;
      in_msg  <= 1'b0;
    end else if (accept) begin
      msg_len <= in_msg ? (msg_len + 32'd1) : 32'd1;
      in_msg  <= !s_last;
    end
  end
`endif

endmodule
